// File: rtl/lop_pipe.sv
// lop_pipe: parametrised two-stage leading-one predictor for the MAC mantissa path.
//
// Predicts the normalisation left shift (leading-zero count) of |a - b| in
// parallel with the subtractor. The prediction out_d is exact or one short.
// out_y flags the one-short case, so out_d + out_y is the true count.
//
// Method: each bit position is classified as a signed digit a_i - b_i, which is
// p (+1), n (-1) or z (0).
// - The indicator f marks the end of the leading z* p n* (or z* n p*) run.
// - The highest set bit of f is the predicted leading-one position P.
// - The true leading one sits one below P exactly when the first nonzero digit
//   strictly below P has the opposite sign to the leading nonzero digit.
// - The combine tree tracks that digit alongside the LOD.
//
// Optional build macro LOP_CORR_CNT_EN adds two ports:
// - corr_cnt, a saturating 16-bit count of transferred results with out_y = 1;
// - corr_clr, a synchronous clear for that counter.
module lop_pipe #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(WIDTH)-1:0] out_d,
  output logic                     out_y,
  output logic                     out_zero,
`ifdef LOP_CORR_CNT_EN
  input  logic                     corr_clr,
  output logic [15:0]              corr_cnt,
`endif
  output logic [TAG_W-1:0]         out_tag
);

  localparam int CW = $clog2(WIDTH);

  // Flow control: a stage advances when it is empty or its consumer advances.
  logic s1_adv, s2_adv;
  logic vld_p1_q, vld_p2_q;

  assign s2_adv   = ~vld_p2_q | out_ready;
  assign s1_adv   = ~vld_p1_q | s2_adv;
  assign in_ready = s1_adv;

  // ---------------- stage 1: digit pre-encoding and indicator ----------------
  logic [WIDTH-1:0] pos_p1_d, neg_p1_d, f_p1_d;
  logic [WIDTH-1:0] e_up_c, p_dn_c, n_dn_c;
  logic             zero_p1_d;

  // pos = digit +1 (a_i=1, b_i=0), neg = digit -1 (a_i=0, b_i=1), else zero digit
  assign pos_p1_d = in_a & ~in_b;
  assign neg_p1_d = ~in_a & in_b;

  // Neighbour views of the digit string.
  // Above the MSB counts as a zero digit; below the LSB counts as a zero digit.
  assign e_up_c = {1'b1, ~(pos_p1_d[WIDTH-1:1] | neg_p1_d[WIDTH-1:1])};
  assign p_dn_c = {pos_p1_d[WIDTH-2:0], 1'b0};
  assign n_dn_c = {neg_p1_d[WIDTH-2:0], 1'b0};

  // Leading digit (zero above): f is set unless the digit below continues the
  // run with the opposite sign.
  // Inside a run (nonzero above): f is set unless the digit below repeats this
  // digit's sign.
  assign f_p1_d = (e_up_c  & ((pos_p1_d & ~n_dn_c) | (neg_p1_d & ~p_dn_c)))
                | (~e_up_c & ((neg_p1_d & ~n_dn_c) | (pos_p1_d & ~p_dn_c)));

  assign zero_p1_d = (in_a == in_b);

  logic [WIDTH-1:0] f_p1_q, pos_p1_q, neg_p1_q;
  logic             zero_p1_q;
  logic [TAG_W-1:0] tag_p1_q;

  // Stage-1 valid: loads on advance, so an empty input cycle leaves a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
    end else if (s1_adv) begin
      vld_p1_q <= in_valid;
    end
  end

  // Stage-1 data: captured only on accept and held while the stage is stalled.
  always_ff @(posedge clk) begin
    if (s1_adv && in_valid) begin
      f_p1_q    <= f_p1_d;
      pos_p1_q  <= pos_p1_d;
      neg_p1_q  <= neg_p1_d;
      zero_p1_q <= zero_p1_d;
      tag_p1_q  <= in_tag;
    end
  end

  // ---------------- stage 2: LOD tree and correction tree ----------------
  // Per node:
  //   v   = some f bit set in the segment;
  //   cnt = leading zeros of f within the segment;
  //   hb  = a nonzero digit exists below the segment's highest f bit;
  //   bp  = that digit is positive;
  //   nz  = the segment has any nonzero digit;
  //   fp  = the first nonzero digit of the segment is positive.
  for (genvar l = 0; l <= CW; l++) begin : g_lvl
    localparam int N = WIDTH >> l;
    logic [N-1:0]         v, hb, bp, nz, fp;
    logic [N-1:0][CW-1:0] cnt;

    if (l == 0) begin : g_leaf
      assign v   = f_p1_q;
      assign hb  = '0;
      assign bp  = '0;
      assign nz  = pos_p1_q | neg_p1_q;
      assign fp  = pos_p1_q;
      assign cnt = '0;
    end else begin : g_node
      localparam logic [CW-1:0] HALF = CW'(1 << (l - 1));
      for (genvar j = 0; j < N; j++) begin : g_cell
        logic          v_hi, v_lo, hb_hi, hb_lo, bp_hi, bp_lo;
        logic          nz_hi, nz_lo, fp_hi, fp_lo;
        logic [CW-1:0] cnt_hi, cnt_lo;

        assign v_hi   = g_lvl[l-1].v[2*j+1];
        assign v_lo   = g_lvl[l-1].v[2*j];
        assign hb_hi  = g_lvl[l-1].hb[2*j+1];
        assign hb_lo  = g_lvl[l-1].hb[2*j];
        assign bp_hi  = g_lvl[l-1].bp[2*j+1];
        assign bp_lo  = g_lvl[l-1].bp[2*j];
        assign nz_hi  = g_lvl[l-1].nz[2*j+1];
        assign nz_lo  = g_lvl[l-1].nz[2*j];
        assign fp_hi  = g_lvl[l-1].fp[2*j+1];
        assign fp_lo  = g_lvl[l-1].fp[2*j];
        assign cnt_hi = g_lvl[l-1].cnt[2*j+1];
        assign cnt_lo = g_lvl[l-1].cnt[2*j];

        // 2-input LOD cell: the upper half wins if it holds any f bit.
        assign v[j]   = v_hi | v_lo;
        assign cnt[j] = v_hi ? cnt_hi : (HALF | cnt_lo);

        // If P lies in the upper half, the digit below P may be in the lower half.
        assign hb[j]  = v_hi ? (hb_hi | nz_lo) : hb_lo;
        assign bp[j]  = v_hi ? (hb_hi ? bp_hi : fp_lo) : bp_lo;

        // First nonzero digit of the combined segment.
        assign nz[j]  = nz_hi | nz_lo;
        assign fp[j]  = nz_hi ? fp_hi : fp_lo;
      end
    end
  end

  logic [CW-1:0] d_p2_d;
  logic          y_p2_d, yp_c, yn_c;

  // Positive result whose first digit below P is negative, or the mirror case.
  assign yp_c = g_lvl[CW].nz[0] &  g_lvl[CW].fp[0] & g_lvl[CW].hb[0] & ~g_lvl[CW].bp[0];
  assign yn_c = g_lvl[CW].nz[0] & ~g_lvl[CW].fp[0] & g_lvl[CW].hb[0] &  g_lvl[CW].bp[0];

  // f is all-zero only when a == b; that case reports a zero shift.
  always_comb begin
    d_p2_d = '0;
    y_p2_d = 1'b0;
    if (g_lvl[CW].v[0]) begin
      d_p2_d = g_lvl[CW].cnt[0];
      y_p2_d = yp_c | yn_c;
    end
  end

  logic [CW-1:0]    d_p2_q;
  logic             y_p2_q, zero_p2_q;
  logic [TAG_W-1:0] tag_p2_q;

  // Output register: advances when empty or drained; a stalled result holds steady.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2_q  <= 1'b0;
      d_p2_q    <= '0;
      y_p2_q    <= 1'b0;
      zero_p2_q <= 1'b0;
      tag_p2_q  <= '0;
    end else if (s2_adv) begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) begin
        d_p2_q    <= d_p2_d;
        y_p2_q    <= y_p2_d;
        zero_p2_q <= zero_p1_q;
        tag_p2_q  <= tag_p1_q;
      end
    end
  end

  assign out_valid = vld_p2_q;
  assign out_d     = d_p2_q;
  assign out_y     = y_p2_q;
  assign out_zero  = zero_p2_q;
  assign out_tag   = tag_p2_q;

`ifdef LOP_CORR_CNT_EN
  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] corr_cnt_q, corr_cnt_d;

  // Count results that actually transfer with the correction flag; clear has priority.
  always_comb begin
    corr_cnt_d = corr_cnt_q;
    if (corr_clr) begin
      corr_cnt_d = '0;
    end else if (vld_p2_q && out_ready && y_p2_q) begin
      corr_cnt_d = sat_inc16(corr_cnt_q);
    end
  end

  // Correction counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt_q <= '0;
    end else begin
      corr_cnt_q <= corr_cnt_d;
    end
  end

  assign corr_cnt = corr_cnt_q;
`endif

endmodule

// File: tb/tb_lop_pipe.sv
// Self-checking bench for lop_pipe at WIDTH=8, TAG_W=4.
// It applies a table of vectors plus corner-case sequences.
// Expected results are queued on accept and compared when a result transfers.
module tb_lop_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = 8'h00;
  logic [7:0] in_b = 8'h00;
  logic [3:0] in_tag = 4'h0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [2:0] out_d;
  logic       out_y;
  logic       out_zero;
  logic [3:0] out_tag;
`ifdef LOP_CORR_CNT_EN
  logic        corr_clr = 1'b0;
  logic [15:0] corr_cnt;
  localparam int EXH_STRIDE = 3;
`else
  localparam int EXH_STRIDE = 1;
`endif

  lop_pipe #(.WIDTH(8), .TAG_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_d     (out_d),
    .out_y     (out_y),
    .out_zero  (out_zero),
`ifdef LOP_CORR_CNT_EN
    .corr_clr  (corr_clr),
    .corr_cnt  (corr_cnt),
`endif
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] tag;
    logic       zero;
    int         lz;
  } vec_t;

  typedef struct {
    logic       zero;
    int         lz;
    logic [3:0] tag;
  } exp_t;

  exp_t       sb[$];
  exp_t       cur;
  vec_t       tbl[16];
  int         n_vec = 0;
  int         n_err = 0;
  int         n_out = 0;
  logic       acc = 1'b0;
  logic       held = 1'b0;
  logic [8:0] snap = '0;

  task automatic chk(input string nm, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  // Reference model: leading zeros of |a-b| in 8 bits.
  function automatic int lz8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] d;
    int n;
    d = (a >= b) ? a - b : b - a;
    n = 0;
    for (int i = 7; i >= 0; i--) begin
      if (d[i]) break;
      n++;
    end
    return n;
  endfunction

  // One clock: observe at the falling edge, then return 1 unit after the rising edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("tag", out_tag, e.tag);
        chk("zero", out_zero, e.zero);
        if (e.zero) chk("zero_d_y", {out_d, out_y}, 0);
        else        chk("d_plus_y", int'(out_d) + int'(out_y), e.lz);
      end
    end
    if (out_valid && !out_ready) begin
      if (held) chk("hold_stable", {out_d, out_y, out_zero, out_tag}, snap);
      held = 1'b1;
      snap = {out_d, out_y, out_zero, out_tag};
    end else begin
      held = 1'b0;
    end
    if (acc) sb.push_back(cur);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [3:0] tag,
                       input logic z, input int lz);
    in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
    cur.zero = z; cur.lz = lz; cur.tag = tag;
    for (int t = 0; t < 50; t++) begin
      step();
      if (acc) break;
    end
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (sb.size() == 0) break;
      step();
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int nd;
    tbl = '{
      '{8'h80, 8'h01, 4'h1, 1'b0, 1}, '{8'h5A, 8'h5A, 4'h2, 1'b1, 0},
      '{8'h01, 8'h80, 4'h3, 1'b0, 1}, '{8'hFF, 8'h00, 4'h4, 1'b0, 0},
      '{8'h00, 8'hFF, 4'h5, 1'b0, 0}, '{8'h02, 8'h01, 4'h6, 1'b0, 7},
      '{8'h10, 8'h0F, 4'h7, 1'b0, 7}, '{8'hF0, 8'h0F, 4'h8, 1'b0, 0},
      '{8'h40, 8'h3F, 4'h9, 1'b0, 7}, '{8'hC0, 8'h41, 4'hA, 1'b0, 1},
      '{8'h00, 8'h01, 4'hB, 1'b0, 7}, '{8'h81, 8'h7F, 4'hC, 1'b0, 6},
      '{8'hA0, 8'h1F, 4'hD, 1'b0, 0}, '{8'h24, 8'h24, 4'hE, 1'b1, 0},
      '{8'h3F, 8'h40, 4'hF, 1'b0, 7}, '{8'h55, 8'hAA, 4'h0, 1'b0, 1}
    };

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_fields", {out_d, out_y, out_zero, out_tag}, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // First three vectors one at a time with latency checks
    for (int k = 0; k < 3; k++) begin
      drive(tbl[k].a, tbl[k].b, tbl[k].tag, tbl[k].zero, tbl[k].lz);
      in_valid = 1'b0;
      chk("lat_cycle1_valid", out_valid, 0);
      step();
      chk("lat_cycle2_valid", out_valid, 1);
      chk("lat_cycle2_tag", out_tag, tbl[k].tag);
      step();
    end

    // Remaining table vectors back to back
    for (int k = 3; k < 16; k++) drive(tbl[k].a, tbl[k].b, tbl[k].tag, tbl[k].zero, tbl[k].lz);
    drain();

    // Backpressure: three ops presented with the consumer stalled
    out_ready = 1'b0;
    n0 = n_out;
    drive(8'h80, 8'h01, 4'h3, 1'b0, 1);
    drive(8'h01, 8'h80, 4'h4, 1'b0, 1);
    in_a = 8'hC0; in_b = 8'h41; in_tag = 4'h5; in_valid = 1'b1;
    cur.zero = 1'b0; cur.lz = 1; cur.tag = 4'h5;
    for (int t = 0; t < 4; t++) begin
      step();
      chk("bp_not_accepted", acc, 0);
    end
    chk("bp_out_valid", out_valid, 1);
    chk("bp_head_tag", out_tag, 3);
    out_ready = 1'b1;
    for (int t = 0; t < 10; t++) begin
      step();
      if (acc) break;
    end
    chk("bp_third_accepted", acc, 1);
    drain();
    chk("bp_result_count", n_out - n0, 3);

    // Asynchronous reset with two ops in flight
    out_ready = 1'b0;
    drive(8'h10, 8'h0F, 4'h6, 1'b0, 7);
    drive(8'hFF, 8'h00, 4'h7, 1'b0, 0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_fields", {out_d, out_y, out_zero, out_tag}, 0);
    sb.delete();
    held = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    n0 = n_out;
    for (int t = 0; t < 4; t++) begin
      step();
      chk("post_rst_idle_valid", out_valid, 0);
    end
    chk("post_rst_no_emit", n_out - n0, 0);
    drive(8'h81, 8'h7F, 4'h8, 1'b0, 6);
    in_valid = 1'b0;
    chk("post_rst_lat1", out_valid, 0);
    step();
    chk("post_rst_lat2", out_valid, 1);
    drain();

    // Exhaustive (or strided) pairs, back to back
    n0 = n_out;
    nd = 0;
    for (int i = 0; i < 65536; i += EXH_STRIDE) begin
      logic [15:0] ab;
      ab = i[15:0];
      drive(ab[15:8], ab[7:0], ab[3:0], ab[15:8] == ab[7:0], lz8(ab[15:8], ab[7:0]));
      nd++;
    end
    chk("exh_one_per_cycle", n_out - n0, nd - 2);
    drain();

`ifdef LOP_CORR_CNT_EN
    corr_clr = 1'b1;
    step();
    corr_clr = 1'b0;
    chk("cnt_cleared", corr_cnt, 0);
    out_ready = 1'b0;
    drive(8'h80, 8'h01, 4'h9, 1'b0, 1);
    in_valid = 1'b0;
    step();
    step();
    chk("cnt_no_transfer", corr_cnt, 0);
    chk("cnt_known_y", out_y, 1);
    out_ready = 1'b1;
    step();
    chk("cnt_after_transfer", corr_cnt, 1);
    drive(8'h80, 8'h01, 4'hA, 1'b0, 1);
    in_valid = 1'b0;
    step();
    corr_clr = 1'b1;
    step();
    corr_clr = 1'b0;
    chk("cnt_clear_wins", corr_cnt, 0);
    drain();
    for (int i = 0; i < 65535; i++) drive(8'h80, 8'h01, i[3:0], 1'b0, 1);
    drain();
    chk("cnt_full", corr_cnt, 16'hFFFF);
    for (int i = 0; i < 3; i++) drive(8'h80, 8'h01, i[3:0], 1'b0, 1);
    drain();
    chk("cnt_saturated", corr_cnt, 16'hFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lop_pipe.md
Name: lop_pipe

Overview:
- Parametrised, pipelined leading-one predictor for the MAC mantissa datapath. Successor to the fixed 4-bit LOP.
- Given two unsigned aligned mantissas a and b, it runs concurrently with the subtractor and predicts the normalisation left-shift of |a−b|.
- Flags when the prediction is one position short, so the normaliser can apply a 1-bit fix-up.
- Two register stages with valid/ready flow control and a sideband tag. Sits between the alignment shifter and the normaliser.

Parameters:
WIDTH, 8, mantissa width in bits; power of two, 4..64
TAG_W, 4, sideband tag width carried alongside each operation (≥1)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept operands this cycle
in_a  in  WIDTH  operand a (unsigned magnitude)
in_b  in  WIDTH  operand b (unsigned magnitude)
in_tag  in  TAG_W  sideband tag, returned unchanged
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_d  out  $clog2(WIDTH)  predicted leading-zero count of |a−b|
out_y  out  1  correction: prediction one short
out_zero  out  1  a == b
out_tag  out  TAG_W  tag of this result

Behaviour:
- Reset (async assert, sync deassert handled upstream): both stage valids clear. out_valid=0, out_d=0, out_y=0, out_zero=0, out_tag=0. In-flight operations are discarded.
- Stage 1 registers:
  - the per-bit indicator vector f[WIDTH-1:0];
  - the positive- and negative-pattern z/p/n pre-encodings;
  - the zero flag (a==b);
  - the tag.
- Stage 2:
  - Leading-one detector tree over f. log2(WIDTH) levels of 2-input LOD cells produce d.
  - Positive- and negative-pattern z/p/n/y combine trees, same depth; y = yp | yn.
  - All of stage 2 is registered into the output.
- Latency: 2 cycles from accept (in_valid & in_ready) to out_valid with no backpressure. Throughput 1/cycle.
- Flow control:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv (combinational from out_ready permitted).
  - Bubbles collapse, and a held stage retains its data. Results leave in order, and none are dropped or duplicated.
- Arithmetic contract for nonzero a−b, with lz = leading zeros of |a−b| in WIDTH bits:
  - out_d ∈ {lz−1, lz}, and out_d + out_y == lz exactly.
  - out_y=1 only when out_d == lz−1.
  - Holds for both signs (a>b and a<b).
- a == b: out_zero=1, out_d=0, out_y=0.
- f all-zero with a≠b cannot occur. Any such case is a design bug.
- out_* stable while out_valid & !out_ready.
- in_valid low: no state change except drains.

Optional Feature:
- Macro LOP_CORR_CNT_EN.
- When defined:
  - Adds output corr_cnt [15:0], a count of transferred results (out_valid & out_ready) with out_y=1.
  - Saturates at 16'hFFFF.
  - Reset to 0 by rst_n.
  - Adds input corr_clr (1 bit), a synchronous clear. Clear wins over a simultaneous increment.
- When undefined: neither port exists, and there is no counter logic.

Test Plan:
- WIDTH=8: a=8'h80, b=8'h01 (|diff|=8'h7F, lz=1) -> after 2 cycles out_valid=1, out_d+out_y=1, out_zero=0, tag echoed.
- a=b=8'h5A -> out_zero=1, out_d=0, out_y=0. Then a=8'h01, b=8'h80 (negative diff) -> out_d+out_y=1.
- Exhaustive 65536 pairs at WIDTH=8, back-to-back, out_ready=1:
  - one result per cycle after 2-cycle fill;
  - out_d+out_y==lz for every nonzero pair;
  - tags in order.
- Backpressure: out_ready=0 while presenting 3 ops -> in_ready falls after 2 accepts, outputs held stable. Release -> 3 results in order, no loss or duplication.
- rst_n pulsed low with 2 ops in flight -> out_valid=0 immediately (async). Nothing emitted after release. Next op returns normally at latency 2.
- LOP_CORR_CNT_EN defined: drive pairs with known y=1 results -> corr_cnt increments only on transfer. corr_clr with coincident increment -> 0. Preload via 65535 y=1 transfers -> holds at 16'hFFFF.
